xor_or_sched: RTL and testbench
===============================

# xor_or_sched

Round-robin scheduler that shares one registered (a ^ b) | c evaluation unit between N requesters. The block arbitrates, captures the winner's operands, and sequences the unit through load, XOR and OR steps, one step per clock. It returns the result with a valid/ready handshake tagged by requester index. It sits between the client blocks and the single shared logic datapath, replacing per-client combinational copies.

## Interface
- W, 8: operand/result width in bits (≥1).
- N, 4: number of requesters (2..16); IW = $clog2(N).
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level; bit i = requester i.
- a_in  in  N*W  operand a; requester i owns bits [i*W +: W]. Same packing for b_in and c_in.
- b_in  in  N*W  operand b.
- c_in  in  N*W  operand c.
- grant  out  N  one-hot, one-cycle pulse: the operands of that requester were captured.
- busy  out  1  high whenever the FSM is not IDLE.
- res_valid  out  1  result available.
- res_data  out  W  result = (a ^ b) | c of the granted request.
- res_id  out  IW  index of the requester that owns res_data.
- res_ready  in  1  consumer accepts the result when res_valid & res_ready.

## Operation
- FSM states: IDLE, XOR, OR, DONE. Reset state IDLE.
- IDLE: if req != 0, select the winner by round-robin and store it in winner. On the same edge:
  - acc <= a_in[winner], b_q <= b_in[winner], c_q <= c_in[winner].
  - res_id <= winner, grant <= onehot(winner), go to XOR.
  - If req == 0, stay in IDLE and drive grant = 0.
- XOR: acc <= acc ^ b_q; grant <= 0; go to OR.
- OR: res_data <= acc | c_q; res_valid <= 1; go to DONE.
- DONE: hold res_data, res_id and res_valid stable.
  - On res_valid & res_ready: res_valid <= 0, ptr <= res_id, go to IDLE.
  - Otherwise stay in DONE. No arbitration takes place in DONE.
- Round-robin: priority search starts at (ptr+1) mod N and wraps. ptr resets to N-1, so requester 0 has first priority after reset.
- Arithmetic: pure bitwise, width W throughout. No carries, no truncation.
- Requester contract:
  - Hold req and operands stable until grant[i] is seen.
  - req is sampled only in IDLE. A req still high in the grant cycle counts as a new request for the next arbitration.
  - A req withdrawn before sampling is never granted.
- res_ready while res_valid = 0 is ignored.
- Reset (rst_n low, any state, including mid-operation):
  - Immediately force state IDLE and grant 0, busy 0, res_valid 0, res_data 0, res_id 0, acc/b_q/c_q 0, ptr N-1.
  - The in-flight operation is discarded and no result is emitted for it.

## Timing
- Edge E0 (IDLE, req sampled): grant is high during cycle E0..E1; busy goes high after E0.
- res_valid rises after E2, i.e. 3 cycles after the sampling edge.
- With res_ready held high: handshake at E3, IDLE after E3, next sampling at E4.
- Peak throughput: one result per 4 cycles. Each cycle of res_ready low in DONE adds one cycle.
- busy falls on the same edge that completes the handshake.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single request: W=8, req=0001, a0=F0, b0=3C, c0=01, res_ready=1.
  - grant=0001 for exactly one cycle after E0.
  - res_valid high after E2 with res_data=CD, res_id=0.
  - busy low after E3.
- Fairness: req=1111 held continuously, res_ready=1.
  - grant sequence 0001, 0010, 0100, 1000, 0001, spaced 4 cycles apart.
  - Each res_id matches its grant.
- Backpressure: res_ready=0 for 10 cycles after res_valid rises.
  - res_valid, res_data and res_id stay constant; no grant pulses.
  - Raise res_ready: exactly one transfer, res_valid low next cycle, next grant one edge later.
- Reset mid-op: drop rst_n asynchronously while in the OR state.
  - All outputs read 0 before the next clock edge.
  - After release with req=1000|0001, requester 0 is granted first.
- Boundaries and wrap-around:
  - a=FF, b=FF, c=00 gives 00; a=00, b=00, c=FF gives FF.
  - After a grant to requester 3 with req=1001, the next grant is 0001 (pointer wraps).
  - A req pulse that falls before the IDLE sampling edge is never granted.

Source files
------------

// File: rtl/xor_or_sched.sv
// xor_or_sched: round-robin arbiter sharing one registered (a ^ b) | c unit among N requesters,
// stepping the unit through load, XOR and OR with a tagged valid/ready result.
module xor_or_sched #(
  parameter int W  = 8,
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  input  logic [N*W-1:0] c_in,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           res_valid,
  output logic [W-1:0]   res_data,
  output logic [IW-1:0]  res_id,
  input  logic           res_ready
);
  typedef enum logic [1:0] {S_IDLE, S_XOR, S_OR, S_DONE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, b_q, b_d, c_q, c_d, data_q, data_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d, ptr_q, ptr_d, win;
  logic          valid_q, valid_d;
  always_comb begin
    win = ptr_q;
    // walk from the farthest slot back so the nearest requester after ptr wins
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr_q) + k) % N]) win = IW'((int'(ptr_q) + k) % N);
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    c_d     = c_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    grant_d = '0;
    case (state_q)
      S_IDLE: if (|req) begin
        acc_d   = a_in[int'(win)*W +: W];
        b_d     = b_in[int'(win)*W +: W];
        c_d     = c_in[int'(win)*W +: W];
        id_d    = win;
        grant_d = N'(1) << win;
        state_d = S_XOR;
      end
      S_XOR: begin
        acc_d   = acc_q ^ b_q;
        state_d = S_OR;
      end
      S_OR: begin
        data_d  = acc_q | c_q;
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      default: if (valid_q && res_ready) begin
        valid_d = 1'b0;
        ptr_d   = id_q;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= IW'(N - 1);
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      c_q     <= c_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end
  assign grant     = grant_q;
  assign busy      = state_q != S_IDLE;
  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_id    = id_q;
endmodule

// File: tb/tb_xor_or_sched.sv
// tb_xor_or_sched: directed scenario tasks for the shared (a ^ b) | c scheduler.
module tb_xor_or_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] a_in = '0, b_in = '0, c_in = '0;
  logic [3:0]  grant;
  logic        busy, res_valid, res_ready = 1'b0;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  int total = 0, bad = 0;
  logic [7:0] exp_d [4] = '{8'h26, 8'h00, 8'hFF, 8'hD9};

  xor_or_sched #(.W(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .grant(grant), .busy(busy), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total++;
    if ({grant, busy, res_valid, res_data, res_id} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {grant, busy, res_valid, res_data, res_id});
    end
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    a_in = 32'h000000F0; b_in = 32'h0000003C; c_in = 32'h00000001;
    req = 4'b0001; res_ready = 1'b1;
    tick;
    total++;
    if (grant !== 4'b0001 || busy !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_grant got=%b/%b/%b exp=0001/1/0", grant, busy, res_valid);
    end
    req = 4'b0000;
    tick;
    total++;
    if (grant !== 4'b0000 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_grant_pulse got=%b/%b exp=0000/0", grant, res_valid);
    end
    tick;
    total++;
    if (res_valid !== 1'b1 || res_data !== 8'hCD || res_id !== 2'd0) begin
      bad++;
      $display("FAIL single_result got=%b/%h/%0d exp=1/cd/0", res_valid, res_data, res_id);
    end
    tick;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got=%b/%b exp=0/0", busy, res_valid);
    end
  endtask

  task automatic test_fairness;
    logic [3:0] eg;
    do_reset;
    a_in = {8'h81, 8'h00, 8'hFF, 8'h12};
    b_in = {8'h18, 8'h00, 8'hFF, 8'h34};
    c_in = {8'h40, 8'hFF, 8'h00, 8'h00};
    req = 4'b1111; res_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << (g % 4);
      tick;
      total++;
      if (grant !== eg) begin
        bad++;
        $display("FAIL fair_grant%0d got=%b exp=%b", g, grant, eg);
      end
      if (g == 4) req = 4'b0000;
      tick;
      tick;
      total++;
      if (res_valid !== 1'b1 || res_id !== 2'(g % 4) || res_data !== exp_d[g % 4]) begin
        bad++;
        $display("FAIL fair_result%0d got=%b/%0d/%h exp=1/%0d/%h", g, res_valid, res_id, res_data, g % 4, exp_d[g % 4]);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    req = 4'b0100; res_ready = 1'b0;
    tick;
    total++;
    if (grant !== 4'b0100) begin
      bad++;
      $display("FAIL bp_grant got=%b exp=0100", grant);
    end
    req = 4'b0000;
    tick;
    tick;
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (res_valid !== 1'b1 || res_data !== 8'hFF || res_id !== 2'd2 || grant !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=1/ff/2/0000", i, res_valid, res_data, res_id, grant);
      end
      tick;
    end
    res_ready = 1'b1;
    tick;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) begin
      bad++;
      $display("FAIL bp_release got=%b/%b/%b exp=0/0/0000", res_valid, busy, grant);
    end
    tick;
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL bp_next_grant got=%b exp=0001", grant);
    end
    req = 4'b0000;
    tick;
    tick;
    tick;
  endtask

  task automatic test_reset_midop;
    req = 4'b1000;
    tick;
    req = 4'b0000;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({grant, busy, res_valid, res_data, res_id} !== 15'd0) begin
      bad++;
      $display("FAIL midop_reset got=%h exp=0", {grant, busy, res_valid, res_data, res_id});
    end
    tick;
    rst_n = 1'b1;
    req = 4'b1001;
  endtask

  task automatic test_wrap;
    tick;
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_first got=%b exp=0001", grant);
    end
    tick;
    tick;
    tick;
    tick;
    total++;
    if (grant !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_r3 got=%b exp=1000", grant);
    end
    tick;
    tick;
    total++;
    if (res_id !== 2'd3 || res_data !== 8'hD9) begin
      bad++;
      $display("FAIL wrap_r3_result got=%0d/%h exp=3/d9", res_id, res_data);
    end
    tick;
    tick;
    total++;
    if (grant !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_back got=%b exp=0001", grant);
    end
    req = 4'b0000;
    tick;
    tick;
    tick;
  endtask

  task automatic test_pulse;
    req = 4'b0010;
    #3;
    req = 4'b0000;
    tick;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        bad++;
        $display("FAIL pulse_ignored%0d got=%b/%b exp=0000/0", i, grant, busy);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_reset_midop;
    test_wrap;
    test_pulse;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
